scarv_cop_mem_rsp: RTL and testbench

Synthesisable memory responder for the COP memory bus: the target end of the `cop_mem_*` interface that `scarv_cop_top` initiates on. It holds a word-addressed RAM and inserts wait states, either fixed or LFSR-driven. It flags errors for misaligned, out-of-range or injected accesses, and keeps saturating access counters. It is used in FPGA bring-up and as the deterministic memory model in directed COP benches.

---
 rtl/scarv_cop_mem_rsp.sv | 129 ++++++++++++
 tb/tb_scarv_cop_mem_rsp.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_mem_rsp.sv
// Target side of the COP memory bus: word RAM with fixed or LFSR-driven wait
// states, error flagging for bad/injected accesses and saturating counters.
module scarv_cop_mem_rsp #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter logic [3:0]  WAIT_STATES = 4'd1,
  parameter bit          RAND_STALL  = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  input  logic        err_inject,
  output logic [15:0] cnt_reads,
  output logic [15:0] cnt_writes,
  output logic [15:0] cnt_errors
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  WCNT_RST = RAND_STALL ? (LFSR_SEED[3:0] & WAIT_STATES)
                                                : WAIT_STATES;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] wait_load(input logic [3:0] s);
    return RAND_STALL ? (s & WAIT_STATES) : WAIT_STATES;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_reads_q, cnt_reads_d;
  logic [15:0] cnt_writes_q, cnt_writes_d;
  logic [15:0] cnt_errors_q, cnt_errors_d;
  logic [31:0] mem_q [DEPTH];

  logic [15:0]   lfsr_nxt;
  logic [31:0]   req_off;
  logic [AW-1:0] req_idx;
  logic          fire;
  logic          acc_err;
  logic          wr_fire;

  always_comb begin
    lfsr_nxt = lfsr_step(lfsr_q);
    req_off  = cop_mem_addr - BASE;
    req_idx  = req_off[AW+1:2];
    fire     = cop_mem_cen && (wcnt_q == 4'd0);
    acc_err  = (cop_mem_addr[1:0] != 2'b00) || (req_off >= SPAN) || err_inject;
    wr_fire  = fire && cop_mem_wen && !acc_err;
  end

  assign cop_mem_stall = cop_mem_cen && (wcnt_q != 4'd0);
  assign cop_mem_error = fire && acc_err;
  assign cop_mem_rdata = (fire && !cop_mem_wen && !acc_err) ? mem_q[req_idx] : 32'h0;
  assign cnt_reads     = cnt_reads_q;
  assign cnt_writes    = cnt_writes_q;
  assign cnt_errors    = cnt_errors_q;

  always_comb begin
    wcnt_d       = wcnt_q;
    lfsr_d       = lfsr_q;
    busy_d       = busy_q;
    cnt_reads_d  = cnt_reads_q;
    cnt_writes_d = cnt_writes_q;
    cnt_errors_d = cnt_errors_q;
    if (fire) begin
      busy_d = 1'b0;
      lfsr_d = lfsr_nxt;
      wcnt_d = wait_load(lfsr_nxt[3:0]);
      if (acc_err) begin
        cnt_errors_d = sat_inc(cnt_errors_q);
      end else if (cop_mem_wen) begin
        cnt_writes_d = sat_inc(cnt_writes_q);
      end else begin
        cnt_reads_d = sat_inc(cnt_reads_q);
      end
    end else if (cop_mem_cen) begin
      wcnt_d = wcnt_q - 4'd1;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Abandoned request: re-arm the wait count but leave the LFSR alone.
      busy_d = 1'b0;
      wcnt_d = wait_load(lfsr_nxt[3:0]);
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wcnt_q       <= WCNT_RST;
      lfsr_q       <= LFSR_SEED;
      busy_q       <= 1'b0;
      cnt_reads_q  <= 16'h0;
      cnt_writes_q <= 16'h0;
      cnt_errors_q <= 16'h0;
    end else begin
      wcnt_q       <= wcnt_d;
      lfsr_q       <= lfsr_d;
      busy_q       <= busy_d;
      cnt_reads_q  <= cnt_reads_d;
      cnt_writes_q <= cnt_writes_d;
      cnt_errors_q <= cnt_errors_d;
    end
  end

  // RAM has no reset; only the byte lanes selected by ben are written.
  always_ff @(posedge g_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_fire && cop_mem_ben[b]) begin
        mem_q[req_idx][8*b +: 8] <= cop_mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_scarv_cop_mem_rsp.sv
// Bench for scarv_cop_mem_rsp: four configurations driven in parallel, checked
// every cycle against a behavioural model plus directed literal expectations.
module tb_scarv_cop_mem_rsp;

  localparam int          NI    = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  function automatic logic [3:0] ws_of(input int i);
    case (i)
      0:       return 4'd0;
      1:       return 4'd2;
      2:       return 4'hF;
      default: return 4'd3;
    endcase
  endfunction

  function automatic bit rnd_of(input int i);
    return i == 2;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        cen   [NI];
  logic        wen   [NI];
  logic        inj   [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  ben   [NI];
  logic [31:0] rdata [NI];
  logic        stall [NI];
  logic        err   [NI];
  logic [15:0] c_rd  [NI];
  logic [15:0] c_wr  [NI];
  logic [15:0] c_er  [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    scarv_cop_mem_rsp #(
      .DEPTH(DEPTH), .BASE(base_of(g)), .WAIT_STATES(ws_of(g)),
      .RAND_STALL(rnd_of(g)), .LFSR_SEED(SEED)
    ) u_dut (
      .g_clk(clk), .g_reset(rst[g]),
      .cop_mem_cen(cen[g]), .cop_mem_wen(wen[g]), .cop_mem_addr(addr[g]),
      .cop_mem_wdata(wdata[g]), .cop_mem_ben(ben[g]), .cop_mem_rdata(rdata[g]),
      .cop_mem_stall(stall[g]), .cop_mem_error(err[g]), .err_inject(inj[g]),
      .cnt_reads(c_rd[g]), .cnt_writes(c_wr[g]), .cnt_errors(c_er[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init [NI];
  int          m_wait [NI];
  logic [15:0] m_lfsr [NI];
  bit          m_busy [NI];
  int          m_rd [NI], m_wr [NI], m_er [NI];
  logic [31:0] m_mem [NI][DEPTH];
  logic [3:0]  m_bv  [NI][DEPTH];

  function automatic logic [15:0] gal(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int reload(input int i, input logic [15:0] s);
    logic [3:0] lo;
    lo = s[3:0];
    return rnd_of(i) ? int'(lo & ws_of(i)) : int'(ws_of(i));
  endfunction

  function automatic int sat(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [31:0] off, exp_rd, mask;
      logic [3:0]  bv;
      bit          fire, ec;
      int          idx;
      fire = cen[i] && (m_wait[i] == 0);
      off  = addr[i] - base_of(i);
      ec   = (addr[i][1:0] != 2'b00) || (off >= 32'(DEPTH * 4)) || inj[i];
      idx  = int'(off[5:2]);
      if (m_init[i]) begin
        exp_rd = 32'h0;
        mask   = 32'hFFFF_FFFF;
        if (fire && !wen[i] && !ec) begin
          bv     = m_bv[i][idx];
          exp_rd = m_mem[i][idx];
          mask   = {{8{bv[3]}}, {8{bv[2]}}, {8{bv[1]}}, {8{bv[0]}}};
        end
        chk($sformatf("stall[%0d]", i), 32'(stall[i]), 32'(cen[i] && m_wait[i] != 0));
        chk($sformatf("error[%0d]", i), 32'(err[i]), 32'(fire && ec));
        chk($sformatf("rdata[%0d]", i), rdata[i] & mask, exp_rd & mask);
        chk($sformatf("cnt_reads[%0d]", i), 32'(c_rd[i]), 32'(m_rd[i]));
        chk($sformatf("cnt_writes[%0d]", i), 32'(c_wr[i]), 32'(m_wr[i]));
        chk($sformatf("cnt_errors[%0d]", i), 32'(c_er[i]), 32'(m_er[i]));
      end
      if (rst[i]) begin
        m_init[i] = 1'b1;
        m_wait[i] = rnd_of(i) ? int'(SEED[3:0] & ws_of(i)) : int'(ws_of(i));
        m_lfsr[i] = SEED;
        m_busy[i] = 1'b0;
        m_rd[i] = 0; m_wr[i] = 0; m_er[i] = 0;
      end else if (m_init[i]) begin
        if (fire) begin
          if (ec) m_er[i] = sat(m_er[i]);
          else if (wen[i]) begin
            m_wr[i] = sat(m_wr[i]);
            for (int b = 0; b < 4; b++) begin
              if (ben[i][b]) begin
                m_mem[i][idx][8*b +: 8] = wdata[i][8*b +: 8];
                m_bv[i][idx][b] = 1'b1;
              end
            end
          end else m_rd[i] = sat(m_rd[i]);
          m_lfsr[i] = gal(m_lfsr[i]);
          m_wait[i] = reload(i, m_lfsr[i]);
          m_busy[i] = 1'b0;
        end else if (cen[i]) begin
          m_wait[i] = m_wait[i] - 1;
          m_busy[i] = 1'b1;
        end else if (m_busy[i]) begin
          m_busy[i] = 1'b0;
          m_wait[i] = reload(i, gal(m_lfsr[i]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit ij,
                     output int stalls, output logic [31:0] rd, output bit er);
    bit got;
    got = 1'b0; stalls = 0; rd = 32'h0; er = 1'b0;
    cen[i] = 1'b1; wen[i] = w; addr[i] = a; wdata[i] = d; ben[i] = b; inj[i] = ij;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (!stall[i]) begin
        got = 1'b1; rd = rdata[i]; er = err[i];
      end else stalls++;
      @(posedge clk); #1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL req_timeout[%0d]: got no completion expected completion within 40 cycles", i);
    end
  endtask

  task automatic idle(input int i, input int n);
    cen[i] = 1'b0; inj[i] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input int i);
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return base_of(i) + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
    if (r == 1) return base_of(i) + 32'(DEPTH * 4 + 4 * $urandom_range(0, 7));
    if (r == 2) return base_of(i) - 32'd4;
    return base_of(i) + 32'(4 * $urandom_range(0, DEPTH - 1));
  endfunction

  task automatic rand_traffic(input int i, input int n);
    bit done;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      done = cen[i] && !stall[i];
      @(posedge clk); #1;
      inj[i] = ($urandom_range(0, 7) == 0);
      if (!cen[i] || done) begin
        if ($urandom_range(0, 3) == 0) cen[i] = 1'b0;
        else begin
          cen[i] = 1'b1; wen[i] = 1'($urandom_range(0, 1)); addr[i] = rand_addr(i);
          wdata[i] = $urandom; ben[i] = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 7) == 0) cen[i] = 1'b0;
    end
    idle(i, 1);
  endtask

  // ---------------- per-configuration scenarios ----------------
  task automatic run0;
    int s; logic [31:0] rd; bit e;
    req(0, 1, 32'h0, 32'h0102_0304, 4'hF, 0, s, rd, e);
    req(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, s, rd, e);
    chk("ws0_write_stalls", 32'(s), 32'd0);
    req(0, 0, 32'h10, 32'h0, 4'h0, 0, s, rd, e);
    chk("ws0_read_stalls", 32'(s), 32'd0);
    chk("ws0_read_data", rd, 32'hDEAD_BEEF);
    idle(0, 1);
    chk("ws0_cnt_writes", 32'(c_wr[0]), 32'd2);
    chk("ws0_cnt_reads", 32'(c_rd[0]), 32'd1);
    req(0, 1, 32'h20, 32'h1122_3344, 4'hF, 0, s, rd, e);
    req(0, 1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, s, rd, e);
    req(0, 0, 32'h20, 32'h0, 4'h0, 0, s, rd, e);
    chk("byte_lanes", rd, 32'h11BB_33DD);
    req(0, 1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, s, rd, e);
    req(0, 0, 32'h20, 32'h0, 4'h0, 0, s, rd, e);
    chk("ben0_noop", rd, 32'h11BB_33DD);
    req(0, 0, 32'h2, 32'h0, 4'h0, 0, s, rd, e);
    chk("misaligned_err", 32'(e), 32'd1);
    chk("misaligned_rdata", rd, 32'h0);
    req(0, 1, 32'(DEPTH * 4), 32'h5, 4'hF, 0, s, rd, e);
    chk("range_err", 32'(e), 32'd1);
    req(0, 0, 32'h10, 32'h0, 4'h0, 1, s, rd, e);
    chk("inject_err", 32'(e), 32'd1);
    req(0, 0, 32'h0, 32'h0, 4'h0, 0, s, rd, e);
    chk("range_ram_unchanged", rd, 32'h0102_0304);
    idle(0, 1);
    chk("cnt_errors_3", 32'(c_er[0]), 32'd3);
    chk("cnt_writes_5", 32'(c_wr[0]), 32'd5);
    chk("cnt_reads_4", 32'(c_rd[0]), 32'd4);
    rand_traffic(0, 400);
  endtask

  task automatic run1;
    int s; logic [31:0] rd; bit e;
    req(1, 0, 32'h0, 32'h0, 4'h0, 0, s, rd, e);
    chk("ws2_stalls", 32'(s), 32'd2);
    idle(1, 1);
    cen[1] = 1'b1; wen[1] = 1'b0; addr[1] = 32'h4;
    @(negedge clk); chk("abandon_stall_T", 32'(stall[1]), 32'd1);
    @(posedge clk); #1; cen[1] = 1'b0;
    @(negedge clk); chk("abandon_stall_off", 32'(stall[1]), 32'd0);
    @(posedge clk); #1;
    chk("abandon_cnt_reads", 32'(c_rd[1]), 32'd1);
    chk("abandon_cnt_errors", 32'(c_er[1]), 32'd0);
    req(1, 0, 32'h4, 32'h0, 4'h0, 0, s, rd, e);
    chk("after_abandon_stalls", 32'(s), 32'd2);
    req(1, 1, 32'h8, 32'hCAFE_F00D, 4'hF, 0, s, rd, e);
    req(1, 0, 32'h8, 32'h0, 4'h0, 0, s, rd, e);
    chk("raw_b2b_data", rd, 32'hCAFE_F00D);
    chk("raw_b2b_stalls", 32'(s), 32'd2);
    rand_traffic(1, 400);
  endtask

  task automatic run2;
    int s; logic [31:0] rd; bit e;
    logic [31:0] img [DEPTH];
    int first [3];
    for (int k = 0; k < DEPTH; k++) begin
      img[k] = $urandom;
      req(2, 1, base_of(2) + 32'(4 * k), img[k], 4'hF, 0, s, rd, e);
      if (k < 3) first[k] = s;
    end
    chk("lfsr_stall_0", 32'(first[0]), 32'd1);
    chk("lfsr_stall_1", 32'(first[1]), 32'd0);
    chk("lfsr_stall_2", 32'(first[2]), 32'd8);
    for (int k = 0; k < 50; k++) begin
      req(2, 0, base_of(2) + 32'(4 * (k % DEPTH)), 32'h0, 4'h0, 0, s, rd, e);
      chk("rand_read_data", rd, img[k % DEPTH]);
    end
    idle(2, 1);
    rand_traffic(2, 300);
  endtask

  task automatic run3;
    int s; logic [31:0] rd; bit e;
    req(3, 1, 32'h0, 32'h7777_1234, 4'hF, 0, s, rd, e);
    chk("ws3_stalls", 32'(s), 32'd3);
    idle(3, 1);
    chk("ws3_cnt_writes", 32'(c_wr[3]), 32'd1);
    cen[3] = 1'b1; wen[3] = 1'b0; addr[3] = 32'h4;
    @(posedge clk); #1; rst[3] = 1'b1;
    @(negedge clk); chk("rst_mid_stall", 32'(stall[3]), 32'd1);
    @(posedge clk); #1; rst[3] = 1'b0; cen[3] = 1'b0;
    @(negedge clk);
    chk("rst_stall_low", 32'(stall[3]), 32'd0);
    chk("rst_cnt_writes", 32'(c_wr[3]), 32'd0);
    @(posedge clk); #1;
    req(3, 0, 32'h0, 32'h0, 4'h0, 0, s, rd, e);
    chk("rst_next_stalls", 32'(s), 32'd3);
    chk("rst_ram_kept", rd, 32'h7777_1234);
    rand_traffic(3, 300);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; cen[i] = 1'b0; wen[i] = 1'b0; inj[i] = 1'b0;
      addr[i] = 32'h0; wdata[i] = 32'h0; ben[i] = 4'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("reset_cnt_reads", 32'(c_rd[i]), 32'd0);
      chk("reset_cnt_writes", 32'(c_wr[i]), 32'd0);
      chk("reset_cnt_errors", 32'(c_er[i]), 32'd0);
    end
    fork
      run0();
      run1();
      run2();
      run3();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
